uart_baud_ctrl: RTL and testbench

Runtime-programmable baud tick controller for the APB UART. It replaces the fixed compile-time divider with a register-loaded divisor. It produces a 16x oversample tick for the receiver and a 1x bit tick for the transmitter. Divisor changes and enable/disable are sequenced so that a bit period is never truncated or glitched. It sits between the APB register block (divisor/enable fields) and the TX/RX shift engines.

---
 rtl/uart_baud_pkg.sv | 19 +
 rtl/uart_baud_ctrl_if.sv | 24 ++
 rtl/uart_tick_prescaler.sv | 25 ++
 rtl/uart_baud_ctrl.sv | 111 +++++++++++
 tb/tb_uart_baud_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/uart_baud_pkg.sv
// Shared types and constants for the runtime-programmable UART baud tick controller.
package uart_baud_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } baud_state_e;

  // Rounded divisor: clk cycles per oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud, input int osr);
    return (clk_hz + (baud * osr) / 2) / (baud * osr);
  endfunction

  // 50 MHz / (115200 * 16), rounded.
  localparam int DEFAULT_DIV_115200 = calc_div(50_000_000, 115_200, 16);
  localparam int MIN_DIV            = 2;

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// Config/enable request and tick outputs between the register block and the baud controller.
interface uart_baud_ctrl_if #(parameter int DIV_W = 16);
  logic             en_i;
  logic             cfg_wr_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic             cfg_busy_o;
  logic             cfg_err_o;
  logic             active_o;
  logic             os_tick_o;
  logic             bit_tick_o;
  logic [DIV_W-1:0] cur_div_o;

  // Register block side.
  modport master (
    output en_i, cfg_wr_i, cfg_div_i,
    input  cfg_busy_o, cfg_err_o, active_o, os_tick_o, bit_tick_o, cur_div_o
  );

  // Baud controller side.
  modport slave (
    input  en_i, cfg_wr_i, cfg_div_i,
    output cfg_busy_o, cfg_err_o, active_o, os_tick_o, bit_tick_o, cur_div_o
  );
endinterface

// File: rtl/uart_tick_prescaler.sv
// Loadable modulo-N counter: counts 0..modulus-1 while enabled, pulses wrap on the last count.
module uart_tick_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modulus,
  output logic         wrap
);

  logic [W-1:0] cnt_q;

  // Modulus is only changed by the owner while cnt_q is 0, so the compare never skips past it.
  assign wrap = en && !clr && (cnt_q == modulus - W'(1));

  // Counter: clear wins, otherwise advance and fold back to 0 on wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_q <= '0;
    else if (clr)  cnt_q <= '0;
    else if (en)   cnt_q <= wrap ? '0 : cnt_q + W'(1);
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud tick controller: 16x oversample tick and 1x bit tick from a register-loaded divisor.
// Divisor changes and disable are deferred to bit boundaries so no bit is ever shortened.
module uart_baud_ctrl
  import uart_baud_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_115200,
  parameter int MIN_DIV     = uart_baud_pkg::MIN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  uart_baud_ctrl_if.slave  bus
);

  localparam int PH_W = $clog2(OSR);

  baud_state_e      state_q, state_d;
  logic [PH_W-1:0]  ph_q;
  logic [DIV_W-1:0] cur_div_q, pend_div_q;
  logic             pend_vld_q;
  logic             os_tick_q, bit_tick_q, cfg_err_q;
  logic             run, os_wrap, bit_wrap, wr_bad, wr_ok;

  assign run      = (state_q != IDLE);
  assign bit_wrap = os_wrap && (ph_q == PH_W'(OSR - 1));
  assign wr_bad   = bus.cfg_wr_i && (bus.cfg_div_i < DIV_W'(MIN_DIV));
  assign wr_ok    = bus.cfg_wr_i && !wr_bad;

  uart_tick_prescaler #(.W(DIV_W)) u_pre (
    .clk     (clk),
    .rst     (rst),
    .clr     (!run),
    .en      (run),
    .modulus (cur_div_q),
    .wrap    (os_wrap)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: DRAIN finishes the current bit; re-enable during DRAIN resumes without a gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en_i)    state_d = RUN;
      RUN:     if (!bus.en_i)   state_d = DRAIN;
      DRAIN:   if (bus.en_i)    state_d = RUN;
               else if (bit_wrap) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Phase counter: os ticks within the current bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ph_q <= '0;
    else if (!run)    ph_q <= '0;
    else if (os_wrap) ph_q <= ph_q + PH_W'(1);
  end

  // Divisor in use: direct load when idle, pending value only at a bit boundary.
  // A value left pending by a write coincident with the final DRAIN boundary is flushed in IDLE,
  // where counters are already at a boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_div_q <= DIV_W'(DEFAULT_DIV);
    end else if (!run) begin
      if (wr_ok)           cur_div_q <= bus.cfg_div_i;
      else if (pend_vld_q) cur_div_q <= pend_div_q;
    end else if (bit_wrap && pend_vld_q) begin
      cur_div_q <= pend_div_q;
    end
  end

  // Pending divisor: last legal write wins; a write on the apply edge becomes the next pending value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_div_q <= '0;
      pend_vld_q <= 1'b0;
    end else if (run && wr_ok) begin
      pend_div_q <= bus.cfg_div_i;
      pend_vld_q <= 1'b1;
    end else if (!run || bit_wrap) begin
      pend_vld_q <= 1'b0;
    end
  end

  // Registered tick and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      os_tick_q  <= os_wrap;
      bit_tick_q <= bit_wrap;
      cfg_err_q  <= wr_bad;
    end
  end

  assign bus.os_tick_o  = os_tick_q;
  assign bus.bit_tick_o = bit_tick_q;
  assign bus.cfg_err_o  = cfg_err_q;
  assign bus.cfg_busy_o = pend_vld_q;
  assign bus.active_o   = run;
  assign bus.cur_div_o  = cur_div_q;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl: tick latency/period, divisor sequencing, drain, reset.
module tb_uart_baud_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;

  uart_baud_ctrl_if #(.DIV_W(16)) bus ();

  uart_baud_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance n edges, sample 1ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait for next os (sel=0) or bit (sel=1) tick; returns cycle stamp or -1.
  task automatic wait_ev(input int sel, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      step(1);
      if ((sel == 0 && bus.os_tick_o) || (sel == 1 && bus.bit_tick_o)) at = cyc;
    end
    if (at < 0) chk(sel ? "bit_timeout" : "os_timeout", 0, 1);
  endtask

  task automatic cfg_write(input int v);
    bus.cfg_wr_i  = 1'b1;
    bus.cfg_div_i = 16'(v);
    step(1);
    bus.cfg_wr_i  = 1'b0;
  endtask

  task automatic wait_os_n(input int n);
    int t;
    for (int k = 0; k < n; k++) wait_ev(0, 200, t);
  endtask

  initial begin
    int e0, t, tp, cnt;
    bus.en_i = 1'b0; bus.cfg_wr_i = 1'b0; bus.cfg_div_i = '0;
    step(3);

    // Reset values
    chk("rst_os", bus.os_tick_o, 0);
    chk("rst_bit", bus.bit_tick_o, 0);
    chk("rst_err", bus.cfg_err_o, 0);
    chk("rst_busy", bus.cfg_busy_o, 0);
    chk("rst_active", bus.active_o, 0);
    chk("rst_div", bus.cur_div_o, 27);

    // Default divisor: os at E0+27, period 27, bit at E0+432, period 432
    rst = 1'b0;
    bus.en_i = 1'b1;
    e0 = cyc + 1;
    wait_ev(0, 100, t);  chk("def_os_first", t - e0, 27);
    chk("def_active", bus.active_o, 1);
    tp = t; wait_ev(0, 100, t); chk("def_os_period", t - tp, 27);
    wait_ev(1, 1000, t); chk("def_bit_first", t - e0, 432);
    tp = t; wait_ev(1, 1000, t); chk("def_bit_period", t - tp, 432);

    // Write 5 mid-bit: current bit stays 432, next is 80
    tp = t; step(50);
    cfg_write(5);
    chk("pend_busy", bus.cfg_busy_o, 1);
    chk("pend_div_hold", bus.cur_div_o, 27);
    wait_ev(1, 1000, t); chk("pend_bit_old", t - tp, 432);
    chk("pend_busy_clr", bus.cfg_busy_o, 0);
    chk("pend_div_new", bus.cur_div_o, 5);
    tp = t; wait_ev(1, 1000, t); chk("pend_bit_new", t - tp, 80);

    // Illegal write with 8 pending: error pulse, pending survives
    tp = t; step(10);
    cfg_write(8);
    chk("p8_busy", bus.cfg_busy_o, 1);
    cfg_write(1);
    chk("err_pulse", bus.cfg_err_o, 1);
    chk("err_keep_busy", bus.cfg_busy_o, 1);
    step(1);
    chk("err_clear", bus.cfg_err_o, 0);
    wait_ev(1, 1000, t); chk("p8_bit_old", t - tp, 80);
    chk("p8_div", bus.cur_div_o, 8);
    tp = t; wait_ev(1, 1000, t); chk("p8_bit_new", t - tp, 128);

    // Drop enable at ph=7: bit completes, then idle
    tp = t;
    wait_os_n(7);
    bus.en_i = 1'b0;
    wait_ev(1, 1000, t); chk("drain_bit", t - tp, 128);
    chk("drain_idle", bus.active_o, 0);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin step(1); cnt += int'(bus.os_tick_o); end
    chk("idle_no_os", cnt, 0);

    // IDLE write 10 applies directly, no busy
    cfg_write(10);
    chk("idle_busy", bus.cfg_busy_o, 0);
    chk("idle_div", bus.cur_div_o, 10);
    bus.en_i = 1'b1;
    e0 = cyc + 1;
    wait_ev(0, 100, t); chk("d10_os_first", t - e0, 10);
    tp = t; wait_ev(0, 100, t); chk("d10_os_period", t - tp, 10);
    wait_ev(1, 1000, t); chk("d10_bit_first", t - e0, 160);

    // Re-enable during DRAIN: no gap, period unchanged
    tp = t;
    wait_os_n(7);
    bus.en_i = 1'b0;
    step(20);
    chk("redrain_active", bus.active_o, 1);
    bus.en_i = 1'b1;
    wait_ev(1, 1000, t); chk("reen_bit", t - tp, 160);
    chk("reen_active", bus.active_o, 1);
    tp = t; wait_ev(1, 1000, t); chk("reen_bit2", t - tp, 160);

    // Reset while running with 12 pending
    step(30);
    cfg_write(12);
    chk("r12_busy", bus.cfg_busy_o, 1);
    step(40);
    rst = 1'b1;
    #1;
    chk("mr_os", bus.os_tick_o, 0);
    chk("mr_bit", bus.bit_tick_o, 0);
    chk("mr_busy", bus.cfg_busy_o, 0);
    chk("mr_active", bus.active_o, 0);
    chk("mr_div", bus.cur_div_o, 27);
    step(2);
    rst = 1'b0;
    e0 = cyc + 1;
    wait_ev(0, 100, t); chk("mr_os_first", t - e0, 27);
    tp = t; wait_ev(0, 100, t); chk("mr_os_period", t - tp, 27);

    bus.en_i = 1'b0;
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
